fc_layer_seq: RTL and testbench
===============================

// Module: fc_layer_seq
// PURPOSE
//  Parametrised, time-multiplexed fully-connected NN layer for the ECG classifier pipeline.
//  Generalises the fixed per-layer blocks chained after the sample ROM.
//  One signed MAC per cycle; weights and biases come from internal ROMs initialised from hex files.
//  Adds valid/ready handshakes, ReLU, saturation and an optional argmax class output.
// PARAMETERS
//  N_IN        16            input vector length
//  N_OUT       8             neurons (output vector length)
//  DATA_W      8             signed activation/weight width
//  ACC_W       24            accumulator width; must be >= 2*DATA_W+$clog2(N_IN)+1
//  FRAC_SH     7             arithmetic right shift applied at requantisation
//  WEIGHT_FILE "weights.hex" N_OUT*N_IN entries, index j*N_IN+i (neuron j, input i)
//  BIAS_FILE   "bias.hex"    N_OUT entries, DATA_W-bit signed
// PORTS
//  clk        in   1                        clock, rising edge
//  reset      in   1                        asynchronous, active-low reset
//  in_valid   in   1                        in_data valid
//  in_ready   out  1                        block accepts a vector
//  in_data    in   N_IN*DATA_W              element i at [i*DATA_W +: DATA_W], signed
//  out_valid  out  1                        out_data valid
//  out_ready  in   1                        consumer accepts result
//  out_data   out  N_OUT*DATA_W             neuron j at [j*DATA_W +: DATA_W], 0..2^(DATA_W-1)-1
//  busy       out  1                        high while in CALC
//  out_class  out  $clog2(N_OUT)            argmax index (only with FC_ARGMAX_EN)
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; in_ready=0, out_valid=0, busy=0, out_data=0, out_class=0,
//    counters i,j=0, acc=0. First edge after release: in_ready=1. Reset mid-CALC aborts; no partial output.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//    IDLE: in_ready=1; accept on in_valid&in_ready; capture in_data; in_ready->0, busy->1, j=0.
//    CALC, per neuron j: 1 BIAS cycle (acc = sext(bias[j]) <<< FRAC_SH, i=0),
//      then N_IN MAC cycles (acc += x[i]*w[j*N_IN+i], full signed product, i++).
//      On the edge of the MAC cycle with i==N_IN-1: r = (acc+prod) >>> FRAC_SH;
//      r<0 -> 0; r>2^(DATA_W-1)-1 -> 2^(DATA_W-1)-1; write out_data[j]; j++.
//      After j==N_OUT-1 is written: go to DONE; out_valid=1, busy=0.
//    DONE: out_data and out_class held stable; in_valid ignored.
//      On out_ready: out_valid->0, in_ready->1, IDLE.
//  - Latency: out_valid rises exactly N_OUT*(N_IN+1) cycles after the accept edge
//    (default 136). Throughput: one vector per N_OUT*(N_IN+1)+2 cycles minimum.
//  - acc wraps modulo 2^ACC_W; no intermediate saturation. The ACC_W bound is checked at elaboration
//    with $error.
//  - out_data keeps its last result after the out handshake until overwritten by the next run.
//    Neurons not yet written in a run keep their previous values; they are not visible, since
//    out_valid=0.
//  - in_data is sampled only at accept; later changes have no effect.
// CONFIGURATION
//  FC_ARGMAX_EN defined: out_class present.
//    - Running max is updated at each neuron write; ties keep the lowest index.
//    - out_class is valid with out_valid; its reset value is 0.
//  Undefined: out_class port and comparator absent; all other behaviour identical.
// TESTING (bench: N_IN=4, N_OUT=3, DATA_W=8, FRAC_SH=0 unless stated)
//  1 all w=1, bias=0, in={1,2,3,4} -> out_data={10,10,10}; out_valid exactly 15 cycles after accept.
//  2 neuron1 w=-1, others w=1 -> out_data[1]=0 (ReLU), others 10.
//  3 in all 127, w all 127, bias 127 -> every output saturates to 127.
//  4 out_ready held low 20 cycles in DONE with in_valid=1 -> out_data stable, in_ready=0,
//    no new accept. Then out_ready=1 -> out_valid=0, in_ready=1 next cycle.
//  5 reset asserted 5 cycles after accept -> all outputs 0 immediately.
//    in_ready=1 one edge after release; a rerun of scenario 1 gives the correct result.
//  6 FC_ARGMAX_EN, biases {5,9,9}, w=0 -> out_data={5,9,9}, out_class=1.

Source files
------------

// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully-connected layer: one signed MAC per cycle, ReLU + saturating requantisation.
// Weight/bias ROM contents arrive as packed parameters WEIGHT_INIT/BIAS_INIT, generated from weights.hex/bias.hex; FC_ARGMAX_EN adds out_class.
module fc_layer_seq #(
    parameter int N_IN    = 16,
    parameter int N_OUT   = 8,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int FRAC_SH = 7,
    // entry k = j*N_IN+i at [k*DATA_W +: DATA_W]
    parameter logic [N_OUT*N_IN*DATA_W-1:0] WEIGHT_INIT = '0,
    // neuron j at [j*DATA_W +: DATA_W]
    parameter logic [N_OUT*DATA_W-1:0]      BIAS_INIT   = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_IN*DATA_W-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_OUT*DATA_W-1:0]   out_data,
    output logic                      busy
`ifdef FC_ARGMAX_EN
    ,
    output logic [(N_OUT > 1 ? $clog2(N_OUT) : 1)-1:0] out_class
`endif
);

    localparam int I_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int J_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int AW  = (N_OUT * N_IN > 1) ? $clog2(N_OUT * N_IN) : 1;
    localparam int P_W = 2 * DATA_W;
    localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (ACC_W < 2 * DATA_W + $clog2(N_IN) + 1) begin : g_acc_w_check
        $error("fc_layer_seq: ACC_W too small for N_IN products of DATA_W operands");
    end

    logic signed [DATA_W-1:0] w_rom [N_OUT*N_IN];
    logic signed [DATA_W-1:0] b_rom [N_OUT];

    for (genvar k = 0; k < N_OUT * N_IN; k++) begin : g_w_rom
        assign w_rom[k] = WEIGHT_INIT[k*DATA_W +: DATA_W];
    end
    for (genvar k = 0; k < N_OUT; k++) begin : g_b_rom
        assign b_rom[k] = BIAS_INIT[k*DATA_W +: DATA_W];
    end

    logic [1:0]               state;
    logic                     bias_phase;
    logic [I_W-1:0]           i_cnt;
    logic [J_W-1:0]           j_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic [DATA_W-1:0]        x_reg   [N_IN];
    logic [DATA_W-1:0]        out_mem [N_OUT];

    logic [AW-1:0]            w_idx;
    logic [DATA_W-1:0]        x_cur;
    logic [DATA_W-1:0]        w_cur;
    logic [DATA_W-1:0]        b_cur;
    logic signed [P_W-1:0]    prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  shifted;
    logic [DATA_W-1:0]        sat_val;

    assign w_idx = AW'(j_cnt) * AW'(N_IN) + AW'(i_cnt);
    assign x_cur = x_reg[i_cnt];
    assign w_cur = w_rom[w_idx];
    assign b_cur = b_rom[j_cnt];

    // Operands sign-extended to the product width so the low P_W bits are the full signed product.
    assign prod     = $signed({{DATA_W{x_cur[DATA_W-1]}}, x_cur})
                    * $signed({{DATA_W{w_cur[DATA_W-1]}}, w_cur});
    assign acc_sum  = acc + {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){b_cur[DATA_W-1]}}, b_cur} <<< FRAC_SH;
    assign shifted  = acc_sum >>> FRAC_SH;

    always_comb begin
        sat_val = shifted[DATA_W-1:0];
        if (shifted[ACC_W-1]) begin
            sat_val = '0;
        end else if (shifted > OUT_MAX) begin
            sat_val = OUT_MAX[DATA_W-1:0];
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out_pack
        assign out_data[k*DATA_W +: DATA_W] = out_mem[k];
    end

`ifdef FC_ARGMAX_EN
    logic [DATA_W-1:0] max_val;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and out_data/out_class stay stable while out_valid is high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            bias_phase <= 1'b0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            acc        <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            for (int k = 0; k < N_IN; k++) begin
                x_reg[k] <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                out_mem[k] <= '0;
            end
`ifdef FC_ARGMAX_EN
            max_val    <= '0;
            out_class  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        for (int k = 0; k < N_IN; k++) begin
                            x_reg[k] <= in_data[k*DATA_W +: DATA_W];
                        end
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        i_cnt      <= '0;
                        j_cnt      <= '0;
                        bias_phase <= 1'b1;
                        state      <= S_CALC;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (bias_phase) begin
                        acc        <= bias_ext;
                        i_cnt      <= '0;
                        bias_phase <= 1'b0;
                    end else begin
                        acc <= acc_sum;
                        if (i_cnt == I_W'(N_IN - 1)) begin
                            out_mem[j_cnt] <= sat_val;
`ifdef FC_ARGMAX_EN
                            // Strict compare keeps the lowest index on ties.
                            if (j_cnt == '0 || sat_val > max_val) begin
                                max_val   <= sat_val;
                                out_class <= j_cnt;
                            end
`endif
                            if (j_cnt == J_W'(N_OUT - 1)) begin
                                state     <= S_DONE;
                                out_valid <= 1'b1;
                                busy      <= 1'b0;
                            end else begin
                                j_cnt      <= j_cnt + J_W'(1);
                                bias_phase <= 1'b1;
                            end
                        end else begin
                            i_cnt <= i_cnt + I_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: four instances with different ROM contents, scoreboard queue plus monitor.
// Build with FC_ARGMAX_EN defined to also check out_class.
module tb_fc_layer_seq;

    localparam int N_IN    = 4;
    localparam int N_OUT   = 3;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 24;
    localparam int FRAC_SH = 0;
    localparam int N_DUT   = 4;
    localparam int XW      = N_IN * DATA_W;
    localparam int OW      = N_OUT * DATA_W;
    localparam int CW      = 2;
    localparam int EW      = 2 + CW + OW;
    localparam int WW      = N_OUT * N_IN * DATA_W;

    // dut0: all w=1 bias 0; dut1: neuron1 w=-1; dut2: everything 127; dut3: w=0, bias {5,9,9}
    localparam logic [N_DUT-1:0][WW-1:0] W_TAB = {
        {WW{1'b0}},
        {12{8'h7F}},
        {{4{8'h01}}, {4{8'hFF}}, {4{8'h01}}},
        {12{8'h01}}
    };
    localparam logic [N_DUT-1:0][OW-1:0] B_TAB = {
        24'h090905,
        {3{8'h7F}},
        24'h000000,
        24'h000000
    };

    logic          clk;
    logic          rst_n;
    logic          in_valid  [N_DUT];
    logic          in_ready  [N_DUT];
    logic [XW-1:0] in_data   [N_DUT];
    logic          out_valid [N_DUT];
    logic          out_ready [N_DUT];
    logic [OW-1:0] out_data  [N_DUT];
    logic          busy      [N_DUT];
`ifdef FC_ARGMAX_EN
    logic [CW-1:0] out_class [N_DUT];
`endif

    int tests_run;
    int tests_failed;
    logic [EW-1:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        fc_layer_seq #(
            .N_IN       (N_IN),
            .N_OUT      (N_OUT),
            .DATA_W     (DATA_W),
            .ACC_W      (ACC_W),
            .FRAC_SH    (FRAC_SH),
            .WEIGHT_INIT(W_TAB[g]),
            .BIAS_INIT  (B_TAB[g])
        ) u_dut (
            .clk      (clk),
            .reset    (rst_n),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .busy     (busy[g])
`ifdef FC_ARGMAX_EN
            ,
            .out_class(out_class[g])
`endif
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < N_DUT; g++) begin
                if (rst_n && out_valid[g] && out_ready[g]) begin
                    if (exp_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL sb_unexpected: dut %0d got 0x%0h, expected no output", g, out_data[g]);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_dut", 32'(g), 32'(e[EW-1 -: 2]));
                        check("sb_data", 32'(out_data[g]), 32'(e[OW-1:0]));
`ifdef FC_ARGMAX_EN
                        check("sb_class", 32'(out_class[g]), 32'(e[OW +: CW]));
`endif
                    end
                end
            end
        end
    end

    // driver: accept one vector on dut k and wait for its result
    task automatic issue(input int k, input logic [XW-1:0] x,
                         input logic [OW-1:0] exp_data, input logic [CW-1:0] exp_cls);
        int n;
        n = 0;
        while (!in_ready[k] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_wait", 32'(in_ready[k]), 32'd1);
        in_data[k]  = x;
        in_valid[k] = 1'b1;
        exp_q.push_back({2'(k), exp_cls, exp_data});
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        check("busy_calc", 32'(busy[k]), 32'd1);
        check("in_ready_calc", 32'(in_ready[k]), 32'd0);
        n = 0;
        while (!out_valid[k] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'd15);
        check("busy_done", 32'(busy[k]), 32'd0);
    endtask

    task automatic drain(input int k);
        out_ready[k] = 1'b1;
        @(posedge clk); #1;
        out_ready[k] = 1'b0;
        check("out_valid_after_hs", 32'(out_valid[k]), 32'd0);
        check("in_ready_after_hs", 32'(in_ready[k]), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b1;
        for (int g = 0; g < N_DUT; g++) begin
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b0;
            in_data[g]   = '0;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < N_DUT; g++) begin
            check("rst_in_ready", 32'(in_ready[g]), 32'd0);
            check("rst_out_valid", 32'(out_valid[g]), 32'd0);
            check("rst_busy", 32'(busy[g]), 32'd0);
            check("rst_out_data", 32'(out_data[g]), 32'd0);
`ifdef FC_ARGMAX_EN
            check("rst_out_class", 32'(out_class[g]), 32'd0);
`endif
        end
        rst_n = 1'b1;
        #1;
        check("in_ready_before_edge", 32'(in_ready[0]), 32'd0);
        @(posedge clk); #1;
        check("in_ready_first_edge", 32'(in_ready[0]), 32'd1);

        // all ones: each neuron sums the inputs
        issue(0, {8'd4, 8'd3, 8'd2, 8'd1}, 24'h0A0A0A, 2'd0);       drain(0);
        issue(0, {8'hFC, 8'hFD, 8'hFE, 8'hFF}, 24'h000000, 2'd0);   drain(0);
        issue(0, {8'hEC, 8'd50, 8'd50, 8'd50}, 24'h7F7F7F, 2'd0);   drain(0);
        issue(0, {8'd0, 8'd0, 8'd0, 8'd127}, 24'h7F7F7F, 2'd0);     drain(0);
        issue(0, {8'd0, 8'd0, 8'd28, 8'd100}, 24'h7F7F7F, 2'd0);    drain(0);
        issue(0, {8'd0, 8'd0, 8'd0, 8'd126}, 24'h7E7E7E, 2'd0);     drain(0);
        issue(0, {8'd0, 8'd0, 8'hFF, 8'd1}, 24'h000000, 2'd0);      drain(0);
        issue(0, {8'd0, 8'd0, 8'd0, 8'd1}, 24'h010101, 2'd0);       drain(0);

        // neuron1 negated
        issue(1, {8'd4, 8'd3, 8'd2, 8'd1}, 24'h0A000A, 2'd0);       drain(1);
        issue(1, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 24'h000400, 2'd1);   drain(1);

        // full-scale saturation
        issue(2, {4{8'h7F}}, 24'h7F7F7F, 2'd0);                     drain(2);

        // bias only; tie between neurons 1 and 2
        issue(3, {8'd4, 8'd3, 8'd2, 8'd1}, 24'h090905, 2'd1);       drain(3);

        // back-pressure in DONE with in_valid asserted
        issue(0, {8'd0, 8'd7, 8'hFD, 8'd5}, 24'h090909, 2'd0);
        in_data[0]  = {4{8'd1}};
        in_valid[0] = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            check("hold_out_data", 32'(out_data[0]), 32'h090909);
            check("hold_in_ready", 32'(in_ready[0]), 32'd0);
            check("hold_out_valid", 32'(out_valid[0]), 32'd1);
        end
        in_valid[0] = 1'b0;
        drain(0);

        // reset during CALC aborts the run
        n = 0;
        while (!in_ready[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        in_data[0]  = {8'd4, 8'd3, 8'd2, 8'd1};
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("abort_busy", 32'(busy[0]), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready[0]), 32'd0);
        check("abort_out_valid", 32'(out_valid[0]), 32'd0);
        check("abort_busy_clr", 32'(busy[0]), 32'd0);
        check("abort_out_data", 32'(out_data[0]), 32'd0);
        check("abort_out_data3", 32'(out_data[3]), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("rerelease_in_ready0", 32'(in_ready[0]), 32'd0);
        @(posedge clk); #1;
        check("rerelease_in_ready1", 32'(in_ready[0]), 32'd1);
        issue(0, {8'd4, 8'd3, 8'd2, 8'd1}, 24'h0A0A0A, 2'd0);       drain(0);

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
